// File: rtl/fcc_req_packer.sv
// fcc_req_packer: packs nine 32-bit host words into one 264-bit NAND request for
// the FCC request FIFO, optionally stamping an auto-incrementing command ID.
module fcc_req_packer #(
    parameter int          WORDS   = 9,
    parameter bit          AUTO_ID = 1'b1,
    parameter logic [15:0] ID_INIT = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_req_valid,
    output logic         s_req_ready,
    input  logic [31:0]  s_req_data,
    input  logic         s_req_last,
    output logic         o_req_valid,
    input  logic         i_req_ready,
    output logic [263:0] o_req_data,
    output logic [31:0]  o_req_cnt,
    output logic [15:0]  o_err_cnt,
    output logic         o_busy
);
    // state   | meaning
    // COLLECT | storing host words into slots, idx = next slot
    // SEND    | request held on o_req_* until the FIFO takes it
    // DISCARD | tail of an over-long frame, dropped up to s_req_last
    typedef enum logic [1:0] {COLLECT, SEND, DISCARD} state_t;

    localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

    state_t          state, state_next;
    logic [3:0]      idx, idx_next;
    logic [7:0][31:0] slots;
    logic [15:0]     id_cnt;
    logic [263:0]    frame;
    logic            word_fire, req_fire;
    logic            store, latch, drop;

    assign s_req_ready = (state != SEND);
    assign word_fire   = s_req_valid & s_req_ready;
    assign req_fire    = o_req_valid & i_req_ready;
    assign o_busy      = (state != COLLECT) | (idx != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            idx   <= 4'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        store      = 1'b0;
        latch      = 1'b0;
        drop       = 1'b0;
        case (state)
            COLLECT: begin
                if (word_fire) begin
                    if (idx == LAST_IDX) begin
                        idx_next = 4'd0;
                        if (s_req_last) begin
                            latch      = 1'b1;
                            state_next = SEND;
                        end else begin
                            drop       = 1'b1;
                            state_next = DISCARD;
                        end
                    end else if (s_req_last) begin
                        drop     = 1'b1;
                        idx_next = 4'd0;
                    end else begin
                        store    = 1'b1;
                        idx_next = idx + 4'd1;
                    end
                end
            end
            SEND: begin
                if (req_fire) state_next = COLLECT;
            end
            DISCARD: begin
                if (word_fire && s_req_last) state_next = COLLECT;
            end
            default: state_next = COLLECT;
        endcase
    end

    // The final word is taken straight off the bus; only its low byte is kept.
    always_comb begin
        frame = {s_req_data[7:0], slots};
        if (AUTO_ID) frame[31:16] = id_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots       <= '0;
            o_req_valid <= 1'b0;
            o_req_data  <= '0;
            o_req_cnt   <= 32'd0;
            o_err_cnt   <= 16'd0;
            id_cnt      <= ID_INIT;
        end else begin
            if (store) slots[idx[2:0]] <= s_req_data;
            if (latch) begin
                o_req_data  <= frame;
                o_req_valid <= 1'b1;
            end else if (req_fire) begin
                o_req_valid <= 1'b0;
            end
            if (req_fire) begin
                o_req_cnt <= o_req_cnt + 32'd1;
                if (AUTO_ID) id_cnt <= id_cnt + 16'd1;
            end
            if (drop && (o_err_cnt != 16'hFFFF)) o_err_cnt <= o_err_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fcc_req_packer.sv
// Bench for fcc_req_packer: expected requests are queued as frames are driven
// and compared when the packer hands a request to the FIFO side.
module tb_fcc_req_packer;
    logic         clk = 1'b0;
    logic         rst;
    logic         s_req_valid;
    logic         s_req_ready;
    logic [31:0]  s_req_data;
    logic         s_req_last;
    logic         o_req_valid;
    logic         i_req_ready;
    logic [263:0] o_req_data;
    logic [31:0]  o_req_cnt;
    logic [15:0]  o_err_cnt;
    logic         o_busy;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [15:0]  exp_id;
    logic [263:0] exp_q[$];

    fcc_req_packer #(.WORDS(9), .AUTO_ID(1'b1), .ID_INIT(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_req_data(s_req_data), .s_req_last(s_req_last),
        .o_req_valid(o_req_valid), .i_req_ready(i_req_ready),
        .o_req_data(o_req_data), .o_req_cnt(o_req_cnt),
        .o_err_cnt(o_err_cnt), .o_busy(o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: a transfer happens at the next rising edge when valid & ready here.
    always @(negedge clk) begin
        if (!rst && o_req_valid && i_req_ready) begin
            logic [263:0] exp;
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_req got=%h", o_req_data);
            end else begin
                exp = exp_q.pop_front();
                if (o_req_data !== exp)
                    $display("FAIL req_data got=%h exp=%h", o_req_data, exp);
                else
                    passed++;
            end
        end
    end

    function automatic logic [8:0][31:0] mk_words(input logic [31:0] base);
        logic [8:0][31:0] w;
        for (int k = 0; k < 9; k++) w[k] = base + 32'(k);
        return w;
    endfunction

    function automatic logic [263:0] mk_req(input logic [8:0][31:0] w, input logic [15:0] id);
        logic [287:0] flat;
        logic [263:0] r;
        flat = w;
        r = flat[263:0];
        r[31:16] = id;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
        else passed++;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_id = 16'h0000;
    endtask

    task automatic put_word(input logic [31:0] d, input logic l);
        int guard = 0;
        s_req_valid = 1'b1;
        s_req_data  = d;
        s_req_last  = l;
        @(negedge clk);
        while (!s_req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_req_ready) begin
            total++;
            $display("FAIL word_accept_timeout got=ready0 exp=ready1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input logic [8:0][31:0] w);
        exp_q.push_back(mk_req(w, exp_id));
        exp_id = exp_id + 16'd1;
        for (int k = 0; k < 9; k++) put_word(w[k], k == 8);
    endtask

    task automatic wait_req_done();
        int guard = 0;
        @(negedge clk);
        while (!(o_req_valid && i_req_ready) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!(o_req_valid && i_req_ready)) begin
            total++;
            $display("FAIL req_timeout got=no_transfer exp=transfer");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_req_valid = 1'b1;
        s_req_data = 32'hFFFF_FFFF;
        s_req_last = 1'b1;
        i_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        apply_reset();
        chk("rst_o_req_valid", 32'(o_req_valid), 32'd0);
        chk("rst_o_req_data_lo", o_req_data[31:0], 32'd0);
        chk("rst_o_req_data_hi", o_req_data[263:232], 32'd0);
        chk("rst_o_req_cnt", o_req_cnt, 32'd0);
        chk("rst_o_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("rst_s_req_ready", 32'(s_req_ready), 32'd1);
        chk("rst_o_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic test_nominal();
        logic [8:0][31:0] w;
        w = mk_words(32'd1);
        i_req_ready = 1'b1;
        send_frame(w);
        s_req_valid = 1'b0;
        chk("nom_valid_after_last", 32'(o_req_valid), 32'd1);
        chk("nom_cmd", 32'(o_req_data[15:0]), 32'h0001);
        chk("nom_cmd_id", 32'(o_req_data[31:16]), 32'h0000);
        chk("nom_top_byte", 32'(o_req_data[263:256]), 32'h09);
        wait_req_done();
        chk("nom_req_cnt", o_req_cnt, 32'd1);
        chk("nom_valid_drop", 32'(o_req_valid), 32'd0);
        chk("nom_ready_back", 32'(s_req_ready), 32'd1);
    endtask

    task automatic test_auto_id();
        logic [8:0][31:0] w;
        int c0;
        apply_reset();
        i_req_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            w = mk_words(32'h1000_0000 + 32'(f * 16));
            w[0][31:16] = 16'hABCD;
            exp_q.push_back(mk_req(w, exp_id));
            exp_id = exp_id + 16'd1;
            for (int k = 0; k < 9; k++) begin
                put_word(w[k], k == 8);
                if (f == 0 && k == 0) c0 = cyc;
            end
        end
        s_req_valid = 1'b0;
        wait_req_done();
        chk("auto_req_cnt", o_req_cnt, 32'd3);
        chk("auto_cycles", 32'(cyc - c0 + 1), 32'd30);
    endtask

    task automatic test_back_pressure();
        logic [8:0][31:0] w;
        logic [263:0] held;
        int bad = 0;
        logic [31:0] cnt0;
        cnt0 = o_req_cnt;
        i_req_ready = 1'b0;
        w = mk_words(32'h2222_0000);
        held = mk_req(w, exp_id);
        send_frame(w);
        s_req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!o_req_valid || o_req_data !== held || s_req_ready || !o_busy) bad++;
        end
        chk("bp_hold_cycles_bad", 32'(bad), 32'd0);
        chk("bp_no_count", o_req_cnt, cnt0);
        @(posedge clk); #1;
        i_req_ready = 1'b1;
        wait_req_done();
        chk("bp_ready_back", 32'(s_req_ready), 32'd1);
        chk("bp_valid_drop", 32'(o_req_valid), 32'd0);
        chk("bp_req_cnt", o_req_cnt, cnt0 + 32'd1);
    endtask

    task automatic test_short_frame();
        logic [15:0] e0;
        logic [31:0] c0;
        e0 = o_err_cnt;
        c0 = o_req_cnt;
        i_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) put_word(32'h5500_0000 + 32'(k), k == 4);
        chk("short_err_cnt", 32'(o_err_cnt), 32'(e0 + 16'd1));
        chk("short_idle", 32'(o_busy), 32'd0);
        send_frame(mk_words(32'h3333_0100));
        s_req_valid = 1'b0;
        wait_req_done();
        chk("short_req_cnt", o_req_cnt, c0 + 32'd1);
    endtask

    task automatic test_long_frame();
        logic [15:0] e0;
        logic [31:0] c0;
        e0 = o_err_cnt;
        c0 = o_req_cnt;
        i_req_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            put_word(32'h6600_0000 + 32'(k), k == 11);
            if (k == 8) begin
                chk("long_err_at_word9", 32'(o_err_cnt), 32'(e0 + 16'd1));
                chk("long_discard_busy", 32'(o_busy), 32'd1);
                chk("long_no_valid", 32'(o_req_valid), 32'd0);
            end
        end
        chk("long_idle_after", 32'(o_busy), 32'd0);
        chk("long_err_cnt", 32'(o_err_cnt), 32'(e0 + 16'd1));
        send_frame(mk_words(32'h4444_0200));
        s_req_valid = 1'b0;
        wait_req_done();
        chk("long_req_cnt", o_req_cnt, c0 + 32'd1);
    endtask

    task automatic test_mid_reset();
        logic [8:0][31:0] w;
        // Pending request killed by reset.
        i_req_ready = 1'b0;
        w = mk_words(32'h7700_0000);
        for (int k = 0; k < 9; k++) put_word(w[k], k == 8);
        s_req_valid = 1'b0;
        chk("mr_pending_valid", 32'(o_req_valid), 32'd1);
        apply_reset();
        chk("mr_pending_dropped", 32'(o_req_valid), 32'd0);
        // Partial frame killed by reset.
        i_req_ready = 1'b1;
        for (int k = 0; k < 4; k++) put_word(32'h8800_0000 + 32'(k), 1'b0);
        chk("mr_partial_busy", 32'(o_busy), 32'd1);
        apply_reset();
        chk("mr_valid", 32'(o_req_valid), 32'd0);
        chk("mr_req_cnt", o_req_cnt, 32'd0);
        chk("mr_err_cnt", 32'(o_err_cnt), 32'd0);
        chk("mr_busy", 32'(o_busy), 32'd0);
        w = mk_words(32'h9900_0000);
        send_frame(w);
        s_req_valid = 1'b0;
        chk("mr_cmd_id", 32'(o_req_data[31:16]), 32'h0000);
        wait_req_done();
        chk("mr_req_cnt_after", o_req_cnt, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        s_req_valid = 1'b0;
        s_req_data = 32'd0;
        s_req_last = 1'b0;
        i_req_ready = 1'b0;
        exp_id = 16'h0000;
        test_reset();
        test_nominal();
        test_auto_id();
        test_back_pressure();
        test_short_frame();
        test_long_frame();
        test_mid_reset();
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
